// File: rtl/cla_add_sequencer_pkg.sv
// Shared types and helpers for the multi-cycle CLA add sequencer.
//   cla_seq_state_t : sequencer FSM state encoding
//   GROUP           : width of one lookahead group cell
//   num_slices()    : number of slice passes needed for one operation
package cla_seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} cla_seq_state_t;

  localparam int GROUP = 4;

  function automatic int num_slices(input int width, input int slice);
    return width / slice;
  endfunction

endpackage

// File: rtl/cla_add_sequencer_if.sv
// Request/response bus of the add sequencer.
//   i_valid/o_ready     : request handshake, operands i_a, i_b, carry-in i_c
//   o_valid/i_ready     : result handshake, sum o_s, carry-out o_c, overflow o_ovf
// master = front end (issues requests, consumes results), slave = sequencer.
interface cla_add_sequencer_if #(parameter int WIDTH = 64);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_c;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_s;
  logic             o_c;
  logic             o_ovf;

  modport master (output i_valid, i_a, i_b, i_c, i_ready,
                  input  o_ready, o_valid, o_s, o_c, o_ovf);
  modport slave  (input  i_valid, i_a, i_b, i_c, i_ready,
                  output o_ready, o_valid, o_s, o_c, o_ovf);
endinterface

// File: rtl/cla_add_sequencer_slice.sv
// Combinational SLICE-bit carry-lookahead adder.
//   cla_logic_4     : 4-bit lookahead cell (bit carries + group G/P)
//   cla_adder_slice : i_a, i_b, i_c -> o_s, o_c ; two-level lookahead tree
//                     (bit level inside cla_logic_4, group level across cells)

module cla_logic_4 (
  input  logic [3:0] g_i,
  input  logic [3:0] p_i,
  input  logic       c_i,
  output logic [3:0] c_o,   // carry into each bit of the group
  output logic       g_o,   // group generate
  output logic       p_o    // group propagate
);
  assign c_o[0] = c_i;
  assign c_o[1] = g_i[0] | (p_i[0] & c_i);
  assign c_o[2] = g_i[1] | (p_i[1] & g_i[0]) | (p_i[1] & p_i[0] & c_i);
  assign c_o[3] = g_i[2] | (p_i[2] & g_i[1]) | (p_i[2] & p_i[1] & g_i[0])
                | (p_i[2] & p_i[1] & p_i[0] & c_i);
  assign g_o    = g_i[3] | (p_i[3] & g_i[2]) | (p_i[3] & p_i[2] & g_i[1])
                | (p_i[3] & p_i[2] & p_i[1] & g_i[0]);
  assign p_o    = &p_i;
endmodule

module cla_adder_slice
  import cla_seq_pkg::*;
#(
  parameter int SLICE = 16
) (
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  input  logic             i_c,
  output logic [SLICE-1:0] o_s,
  output logic             o_c
);
  localparam int NG = SLICE / GROUP;

  if (SLICE % GROUP != 0) begin : g_bad_slice
    $error("SLICE must be a multiple of 4");
  end

  logic [SLICE-1:0] g, p, c;
  logic [NG-1:0]    gg, pg;
  logic [NG:0]      cg;     // carry into each group; cg[NG] is the slice carry-out

  assign g = i_a & i_b;
  assign p = i_a ^ i_b;

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    cla_logic_4 u_cla (
      .g_i (g[gi*GROUP +: GROUP]),
      .p_i (p[gi*GROUP +: GROUP]),
      .c_i (cg[gi]),
      .c_o (c[gi*GROUP +: GROUP]),
      .g_o (gg[gi]),
      .p_o (pg[gi])
    );
  end

  // Group-level lookahead, written as the flat sum of products
  //   cg[j] = OR_i (gg[i] & pg[i+1..j-1]) | (i_c & pg[0..j-1])
  // so every group carry is two gate levels from the group G/P terms.
  logic acc, term;
  always_comb begin
    cg   = '0;
    acc  = 1'b0;
    term = 1'b0;
    cg[0] = i_c;
    for (int j = 1; j <= NG; j++) begin
      acc = 1'b0;
      for (int i = 0; i < j; i++) begin
        term = gg[i];
        for (int k = i + 1; k < j; k++) term = term & pg[k];
        acc = acc | term;
      end
      term = i_c;
      for (int k = 0; k < j; k++) term = term & pg[k];
      cg[j] = acc | term;
    end
  end

  assign o_s = p ^ c;
  assign o_c = cg[NG];
endmodule

// File: rtl/cla_add_sequencer.sv
// Multi-cycle WIDTH-bit adder that time-shares one SLICE-bit CLA slice,
// one slice per cycle LSB first, with the inter-slice carry held in carry_q.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (slave)  : request i_valid/o_ready/i_a/i_b/i_c,
//                  result  o_valid/i_ready/o_s/o_c/o_ovf
// Accept in IDLE, K RUN cycles, then hold the result in DONE until taken.
module cla_add_sequencer
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  cla_add_sequencer_if.slave  bus
);
  localparam int K  = num_slices(WIDTH, SLICE);
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IW-1:0] LAST = IW'(K - 1);

  if (WIDTH % SLICE != 0) begin : g_bad_width
    $error("WIDTH must be a multiple of SLICE");
  end

  cla_seq_state_t   state_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic             carry_q;
  logic             valid_q, ready_q;

  logic [SLICE-1:0] slice_s;
  logic             slice_c;

  cla_adder_slice #(.SLICE(SLICE)) u_slice (
    .i_a (a_q[idx_q*SLICE +: SLICE]),
    .i_b (b_q[idx_q*SLICE +: SLICE]),
    .i_c (carry_q),
    .o_s (slice_s),
    .o_c (slice_c)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: if (bus.i_valid) begin
          a_q     <= bus.i_a;
          b_q     <= bus.i_b;
          carry_q <= bus.i_c;
          s_q     <= '0;
          idx_q   <= '0;
          ready_q <= 1'b0;
          state_q <= RUN;
        end
        RUN: begin
          s_q[idx_q*SLICE +: SLICE] <= slice_s;
          carry_q <= slice_c;
          if (idx_q == LAST) begin
            idx_q   <= '0;
            valid_q <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: if (bus.i_ready) begin
          // No acceptance here: o_ready only rises once back in IDLE.
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_s     = s_q;
  assign bus.o_c     = carry_q;
  assign bus.o_ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s_q[WIDTH-1] != a_q[WIDTH-1]);
  assign bus.o_valid = valid_q;
  assign bus.o_ready = ready_q;
endmodule

// File: tb/tb_cla_add_sequencer.sv
module tb_cla_add_sequencer;
  localparam int K = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  cla_add_sequencer_if #(.WIDTH(64)) bus   ();
  cla_add_sequencer_if #(.WIDTH(16)) bus16 ();

  cla_add_sequencer #(.WIDTH(64), .SLICE(16)) dut (
    .i_clk (clk), .i_rst (rst), .bus (bus)
  );
  cla_add_sequencer #(.WIDTH(16), .SLICE(16)) dut16 (
    .i_clk (clk), .i_rst (rst), .bus (bus16)
  );

  // Golden model: plain wide arithmetic.
  function automatic logic [64:0] ref_sum(input logic [63:0] a, b, input logic ci);
    return {1'b0, a} + {1'b0, b} + {64'd0, ci};
  endfunction

  // Signed overflow: the true signed sum does not fit in 64 bits.
  function automatic logic ref_ovf(input logic [63:0] a, b, input logic ci);
    logic signed [65:0] t;
    t = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b}) + $signed({65'd0, ci});
    return t[65:63] != {3{t[63]}};
  endfunction

  // One full operation on the 64-bit DUT, starting and ending at a negedge.
  // stalls: DONE cycles with i_ready low; junk: drive new requests meanwhile.
  task automatic run_op(input logic [63:0] a, b, input logic ci,
                        input int stalls, input bit junk, input string nm);
    logic [64:0] exp;
    logic        eovf;
    logic [63:0] hs;
    logic        hc, hv;
    int          w, lat;
    exp  = ref_sum(a, b, ci);
    eovf = ref_ovf(a, b, ci);
    w = 0;
    while (!bus.o_ready && w < 20) begin @(negedge clk); w++; end
    total++;
    if (bus.o_ready !== 1'b1) begin
      bad++; $display("FAIL %s ready_wait got=%b want=1", nm, bus.o_ready);
    end
    bus.i_valid = 1'b1; bus.i_a = a; bus.i_b = b; bus.i_c = ci;
    @(negedge clk);
    lat = 1;
    bus.i_valid = 1'b0;
    bus.i_a = {$urandom, $urandom}; bus.i_b = {$urandom, $urandom}; bus.i_c = 1'($urandom);
    bus.i_ready = (stalls == 0);
    while (!bus.o_valid && lat < 20) begin @(negedge clk); lat++; end
    total++;
    if (lat != K + 1) begin
      bad++; $display("FAIL %s latency got=%0d want=%0d", nm, lat, K + 1);
    end
    total++;
    if (bus.o_s !== exp[63:0]) begin
      bad++; $display("FAIL %s sum got=%h want=%h", nm, bus.o_s, exp[63:0]);
    end
    total++;
    if (bus.o_c !== exp[64]) begin
      bad++; $display("FAIL %s carry got=%b want=%b", nm, bus.o_c, exp[64]);
    end
    total++;
    if (bus.o_ovf !== eovf) begin
      bad++; $display("FAIL %s ovf got=%b want=%b", nm, bus.o_ovf, eovf);
    end
    hs = bus.o_s; hc = bus.o_c; hv = bus.o_ovf;
    for (int i = 0; i < stalls; i++) begin
      if (junk) begin
        bus.i_valid = 1'b1; bus.i_a = {$urandom, $urandom}; bus.i_b = {$urandom, $urandom};
      end
      @(negedge clk);
      total++;
      if (bus.o_valid !== 1'b1 || bus.o_ready !== 1'b0 || bus.o_s !== hs ||
          bus.o_c !== hc || bus.o_ovf !== hv) begin
        bad++;
        $display("FAIL %s hold v=%b r=%b s=%h c=%b o=%b want v=1 r=0 s=%h c=%b o=%b",
                 nm, bus.o_valid, bus.o_ready, bus.o_s, bus.o_c, bus.o_ovf, hs, hc, hv);
      end
    end
    bus.i_ready = 1'b1;
    @(negedge clk);
    total++;
    if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
      bad++; $display("FAIL %s release v=%b r=%b want v=0 r=1", nm, bus.o_valid, bus.o_ready);
    end
    bus.i_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    total++;
    if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_s !== 64'd0 ||
        bus.o_c !== 1'b0 || bus.o_ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_state r=%b v=%b s=%h c=%b o=%b want r=1 v=0 s=0 c=0 o=0",
               bus.o_ready, bus.o_valid, bus.o_s, bus.o_c, bus.o_ovf);
    end
  endtask

  task automatic test_directed();
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 0, 1'b0, "ripple");
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 0, 1'b0, "ovf_pos");
    run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 0, 1'b0, "ovf_neg");
    run_op(64'h0000_FFFF_0000_FFFF, 64'h0, 1'b1, 0, 1'b0, "cin_boundary");
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0, 1'b0, "all_ones");
  endtask

  task automatic test_backpressure();
    run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 3, 1'b1, "backpressure");
  endtask

  task automatic test_reset_mid_run();
    bus.i_valid = 1'b1;
    bus.i_a = 64'hFFFF_FFFF_FFFF_FFFF; bus.i_b = 64'h1234_1234_1234_1234; bus.i_c = 1'b0;
    @(negedge clk);          // accepted; now RUN cycle 1
    bus.i_valid = 1'b0;
    @(negedge clk);          // RUN cycle 2
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_s !== 64'd0 ||
        bus.o_c !== 1'b0 || bus.o_ovf !== 1'b0) begin
      bad++;
      $display("FAIL mid_run_reset v=%b r=%b s=%h c=%b o=%b want v=0 r=1 s=0 c=0 o=0",
               bus.o_valid, bus.o_ready, bus.o_s, bus.o_c, bus.o_ovf);
    end
    run_op(64'd5, 64'd7, 1'b0, 0, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 1000; n++) begin
      logic [63:0] a, b;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: a = 64'hFFFF_FFFF_FFFF_FFFF;
        1: b = ~a;
        default: ;
      endcase
      run_op(a, b, 1'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
             ($urandom_range(0, 3) == 0), "random");
    end
  endtask

  task automatic test_k1();
    int lat;
    total++;
    if (bus16.o_ready !== 1'b1) begin
      bad++; $display("FAIL k1_ready got=%b want=1", bus16.o_ready);
    end
    bus16.i_valid = 1'b1; bus16.i_a = 16'hFFFF; bus16.i_b = 16'h0001; bus16.i_c = 1'b0;
    @(negedge clk);
    lat = 1;
    bus16.i_valid = 1'b0;
    while (!bus16.o_valid && lat < 20) begin @(negedge clk); lat++; end
    total++;
    if (lat != 2) begin
      bad++; $display("FAIL k1_latency got=%0d want=2", lat);
    end
    total++;
    if (bus16.o_s !== 16'h0000 || bus16.o_c !== 1'b1 || bus16.o_ovf !== 1'b0) begin
      bad++;
      $display("FAIL k1_result s=%h c=%b o=%b want s=0000 c=1 o=0",
               bus16.o_s, bus16.o_c, bus16.o_ovf);
    end
    @(negedge clk);
    total++;
    if (bus16.o_valid !== 1'b0 || bus16.o_ready !== 1'b1) begin
      bad++; $display("FAIL k1_release v=%b r=%b want v=0 r=1", bus16.o_valid, bus16.o_ready);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.i_valid = 1'b0; bus.i_a = '0; bus.i_b = '0; bus.i_c = 1'b0; bus.i_ready = 1'b1;
    bus16.i_valid = 1'b0; bus16.i_a = '0; bus16.i_b = '0; bus16.i_c = 1'b0; bus16.i_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_k1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
